// File: rtl/l1_data_mem_responder.sv
// L1 data cache memory-side responder: request queue, lane steering, ordered responses.
// Optional MIST1032ISA_DATA_RESP_PF_SQUASH_EN drops same-line reads after a faulting read.
module l1_data_mem_responder #(
    parameter int P_REQ_DEPTH    = 4,
    parameter int P_REQ_DEPTH_N  = 2,
    parameter int P_OUTS_DEPTH   = 8,
    parameter int P_OUTS_DEPTH_N = 3
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iREMOVE,
    input  logic        iCACHE_REQ,
    output logic        oCACHE_LOCK,
    input  logic [1:0]  iCACHE_ORDER,
    input  logic        iCACHE_RW,
    input  logic [13:0] iCACHE_TID,
    input  logic [1:0]  iCACHE_MMUMOD,
    input  logic [31:0] iCACHE_PDT,
    input  logic [31:0] iCACHE_ADDR,
    input  logic [31:0] iCACHE_DATA,
    output logic        oCACHE_VALID,
    output logic        oCACHE_PAGEFAULT,
    output logic [27:0] oCACHE_MMU_FLAGS,
    output logic [63:0] oCACHE_DATA,
    output logic        oMEM_REQ,
    input  logic        iMEM_LOCK,
    output logic        oMEM_RW,
    output logic [13:0] oMEM_TID,
    output logic [1:0]  oMEM_MMUMOD,
    output logic [31:0] oMEM_PDT,
    output logic [31:0] oMEM_ADDR,
    output logic [7:0]  oMEM_BE,
    output logic [63:0] oMEM_DATA,
    input  logic        iMEM_VALID,
    input  logic        iMEM_PAGEFAULT,
    input  logic [27:0] iMEM_MMU_FLAGS,
    input  logic [63:0] iMEM_DATA,
    output logic        oERR_SPURIOUS
);

    typedef struct packed {
        logic        rw;
        logic [1:0]  order;
        logic [13:0] tid;
        logic [1:0]  mmumod;
        logic [31:0] pdt;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    localparam logic [P_REQ_DEPTH_N:0]  L_REQ_FULL  = (P_REQ_DEPTH_N+1)'(P_REQ_DEPTH);
    localparam logic [P_OUTS_DEPTH_N:0] L_OUTS_FULL = (P_OUTS_DEPTH_N+1)'(P_OUTS_DEPTH);

    req_t                      r_req_mem [P_REQ_DEPTH];
    logic [P_REQ_DEPTH_N-1:0]  r_req_wp;
    logic [P_REQ_DEPTH_N-1:0]  r_req_rp;
    logic [P_REQ_DEPTH_N:0]    r_req_count;

    logic [26:0]               r_outs_mem [P_OUTS_DEPTH];
    logic [P_OUTS_DEPTH_N-1:0] r_outs_wp;
    logic [P_OUTS_DEPTH_N-1:0] r_outs_rp;
    logic [P_OUTS_DEPTH_N:0]   r_outs_count;

    logic        r_cvalid;
    logic        r_cpf;
    logic [27:0] r_cflags;
    logic [63:0] r_cdata;
    logic        r_spur;

    logic        w_req_empty;
    logic        w_req_push;
    logic        w_issue;
    logic        w_outs_empty;
    logic        w_rsp_pop;
    logic        w_fwd;
    req_t        w_head;
    req_t        w_in;
    logic [26:0] w_outs_head;
    logic        w_head_rw;
    logic [25:0] w_head_tag;

    assign w_in = '{rw: iCACHE_RW, order: iCACHE_ORDER, tid: iCACHE_TID,
                    mmumod: iCACHE_MMUMOD, pdt: iCACHE_PDT,
                    addr: iCACHE_ADDR, data: iCACHE_DATA};

    assign w_req_empty  = (r_req_count == '0);
    assign w_outs_empty = (r_outs_count == '0);
    assign oCACHE_LOCK  = (r_req_count == L_REQ_FULL) || iREMOVE;
    assign w_req_push   = iCACHE_REQ && !oCACHE_LOCK;
    assign oMEM_REQ     = !w_req_empty && (r_outs_count != L_OUTS_FULL) && !iREMOVE;
    assign w_issue      = oMEM_REQ && !iMEM_LOCK;
    assign w_rsp_pop    = iMEM_VALID && !w_outs_empty;

    assign w_head      = r_req_mem[r_req_rp];
    assign w_outs_head = r_outs_mem[r_outs_rp];
    assign w_head_rw   = w_outs_head[26];
    assign w_head_tag  = w_outs_head[25:0];

    always_ff @(posedge iCLOCK) begin
        if (w_req_push) r_req_mem[r_req_wp] <= w_in;
        if (w_issue) r_outs_mem[r_outs_wp] <= {w_head.rw, w_head.addr[31:6]};
    end

    // iREMOVE wins over everything in the request queue; push/issue are already blocked
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_req_wp    <= '0;
            r_req_rp    <= '0;
            r_req_count <= '0;
        end else if (iREMOVE) begin
            r_req_wp    <= '0;
            r_req_rp    <= '0;
            r_req_count <= '0;
        end else begin
            if (w_req_push) r_req_wp <= r_req_wp + 1'b1;
            if (w_issue) r_req_rp <= r_req_rp + 1'b1;
            unique case ({w_req_push, w_issue})
                2'b10:   r_req_count <= r_req_count + 1'b1;
                2'b01:   r_req_count <= r_req_count - 1'b1;
                default: r_req_count <= r_req_count;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_outs_wp    <= '0;
            r_outs_rp    <= '0;
            r_outs_count <= '0;
        end else begin
            if (w_issue) r_outs_wp <= r_outs_wp + 1'b1;
            if (w_rsp_pop) r_outs_rp <= r_outs_rp + 1'b1;
            unique case ({w_issue, w_rsp_pop})
                2'b10:   r_outs_count <= r_outs_count + 1'b1;
                2'b01:   r_outs_count <= r_outs_count - 1'b1;
                default: r_outs_count <= r_outs_count;
            endcase
        end
    end

    always_comb begin
        oMEM_RW     = 1'b0;
        oMEM_TID    = '0;
        oMEM_MMUMOD = '0;
        oMEM_PDT    = '0;
        oMEM_ADDR   = '0;
        oMEM_BE     = '0;
        oMEM_DATA   = '0;
        if (!w_req_empty) begin
            oMEM_RW     = w_head.rw;
            oMEM_TID    = w_head.tid;
            oMEM_MMUMOD = w_head.mmumod;
            oMEM_PDT    = w_head.pdt;
            oMEM_ADDR   = w_head.addr;
            oMEM_BE     = 8'hFF;
            oMEM_DATA   = {2{w_head.data}};
            if (!w_head.rw) begin
                unique case (w_head.order)
                    2'd0: begin
                        oMEM_BE   = 8'h01 << w_head.addr[2:0];
                        oMEM_DATA = {8{w_head.data[7:0]}};
                    end
                    2'd1: begin
                        oMEM_BE   = 8'h03 << {w_head.addr[2:1], 1'b0};
                        oMEM_DATA = {4{w_head.data[15:0]}};
                    end
                    2'd2: begin
                        oMEM_BE   = 8'h0F << {w_head.addr[2], 2'b00};
                        oMEM_DATA = {2{w_head.data}};
                    end
                    default: begin
                        oMEM_BE   = 8'hFF;
                        oMEM_DATA = {2{w_head.data}};
                    end
                endcase
            end
        end
    end

`ifdef MIST1032ISA_DATA_RESP_PF_SQUASH_EN
    typedef enum logic {S_IDLE, S_SQUASH} sq_t;

    sq_t         r_state;
    sq_t         w_state_nxt;
    logic [25:0] r_tag;
    logic [25:0] w_tag_nxt;
    logic        w_match;

    assign w_match = !w_outs_empty && w_head_rw && (w_head_tag == r_tag);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= S_IDLE;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tag   <= w_tag_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tag_nxt   = r_tag;
        if (w_fwd && iMEM_PAGEFAULT && w_head_rw) begin
            w_state_nxt = S_SQUASH;
            w_tag_nxt   = w_head_tag;
        end else if (r_state == S_SQUASH && !w_match) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        w_fwd = w_rsp_pop;
        if (r_state == S_SQUASH && w_match) w_fwd = 1'b0;
    end
`else
    logic w_unused_outs;
    assign w_unused_outs = ^{w_head_rw, w_head_tag};
    assign w_fwd = w_rsp_pop;
`endif

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_cvalid <= 1'b0;
            r_cpf    <= 1'b0;
            r_cflags <= '0;
            r_cdata  <= '0;
            r_spur   <= 1'b0;
        end else begin
            r_cvalid <= w_fwd;
            if (w_fwd) begin
                r_cpf    <= iMEM_PAGEFAULT;
                r_cflags <= iMEM_MMU_FLAGS;
                r_cdata  <= iMEM_DATA;
            end
            if (iMEM_VALID && w_outs_empty) r_spur <= 1'b1;
        end
    end

    assign oCACHE_VALID     = r_cvalid;
    assign oCACHE_PAGEFAULT = r_cpf;
    assign oCACHE_MMU_FLAGS = r_cflags;
    assign oCACHE_DATA      = r_cdata;
    assign oERR_SPURIOUS    = r_spur;

endmodule

// File: tb/tb_l1_data_mem_responder.sv
// Directed testbench for l1_data_mem_responder.
// Squash expectations follow MIST1032ISA_DATA_RESP_PF_SQUASH_EN.
module tb_l1_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        iREMOVE;
    logic        iCACHE_REQ;
    logic        oCACHE_LOCK;
    logic [1:0]  iCACHE_ORDER;
    logic        iCACHE_RW;
    logic [13:0] iCACHE_TID;
    logic [1:0]  iCACHE_MMUMOD;
    logic [31:0] iCACHE_PDT;
    logic [31:0] iCACHE_ADDR;
    logic [31:0] iCACHE_DATA;
    logic        oCACHE_VALID;
    logic        oCACHE_PAGEFAULT;
    logic [27:0] oCACHE_MMU_FLAGS;
    logic [63:0] oCACHE_DATA;
    logic        oMEM_REQ;
    logic        iMEM_LOCK;
    logic        oMEM_RW;
    logic [13:0] oMEM_TID;
    logic [1:0]  oMEM_MMUMOD;
    logic [31:0] oMEM_PDT;
    logic [31:0] oMEM_ADDR;
    logic [7:0]  oMEM_BE;
    logic [63:0] oMEM_DATA;
    logic        iMEM_VALID;
    logic        iMEM_PAGEFAULT;
    logic [27:0] iMEM_MMU_FLAGS;
    logic [63:0] iMEM_DATA;
    logic        oERR_SPURIOUS;

    int checks = 0;
    int passed = 0;

    l1_data_mem_responder dut (
        .iCLOCK(clk), .inRESET(rst_n), .iREMOVE(iREMOVE),
        .iCACHE_REQ(iCACHE_REQ), .oCACHE_LOCK(oCACHE_LOCK),
        .iCACHE_ORDER(iCACHE_ORDER), .iCACHE_RW(iCACHE_RW),
        .iCACHE_TID(iCACHE_TID), .iCACHE_MMUMOD(iCACHE_MMUMOD),
        .iCACHE_PDT(iCACHE_PDT), .iCACHE_ADDR(iCACHE_ADDR),
        .iCACHE_DATA(iCACHE_DATA), .oCACHE_VALID(oCACHE_VALID),
        .oCACHE_PAGEFAULT(oCACHE_PAGEFAULT),
        .oCACHE_MMU_FLAGS(oCACHE_MMU_FLAGS), .oCACHE_DATA(oCACHE_DATA),
        .oMEM_REQ(oMEM_REQ), .iMEM_LOCK(iMEM_LOCK), .oMEM_RW(oMEM_RW),
        .oMEM_TID(oMEM_TID), .oMEM_MMUMOD(oMEM_MMUMOD),
        .oMEM_PDT(oMEM_PDT), .oMEM_ADDR(oMEM_ADDR), .oMEM_BE(oMEM_BE),
        .oMEM_DATA(oMEM_DATA), .iMEM_VALID(iMEM_VALID),
        .iMEM_PAGEFAULT(iMEM_PAGEFAULT), .iMEM_MMU_FLAGS(iMEM_MMU_FLAGS),
        .iMEM_DATA(iMEM_DATA), .oERR_SPURIOUS(oERR_SPURIOUS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic rw, input logic [1:0] ord,
                           input logic [31:0] a, input logic [31:0] d);
        iCACHE_REQ   = 1'b1;
        iCACHE_RW    = rw;
        iCACHE_ORDER = ord;
        iCACHE_ADDR  = a;
        iCACHE_DATA  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iREMOVE = 0; iCACHE_REQ = 0; iCACHE_ORDER = 0; iCACHE_RW = 0;
        iCACHE_TID = 14'h0055; iCACHE_MMUMOD = 2'd1;
        iCACHE_PDT = 32'hCAFE_0000; iCACHE_ADDR = 0; iCACHE_DATA = 0;
        iMEM_LOCK = 0; iMEM_VALID = 0; iMEM_PAGEFAULT = 0;
        iMEM_MMU_FLAGS = 0; iMEM_DATA = 0;
        step(); step();
        checks++;
        if (oCACHE_LOCK !== 1'b0) $display("FAIL reset_lock got %b want 0", oCACHE_LOCK);
        else passed++;
        checks++;
        if (oMEM_REQ !== 1'b0) $display("FAIL reset_memreq got %b want 0", oMEM_REQ);
        else passed++;
        checks++;
        if (oCACHE_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", oCACHE_VALID);
        else passed++;
        checks++;
        if (oMEM_BE !== 8'h00) $display("FAIL reset_be got %h want 00", oMEM_BE);
        else passed++;
        checks++;
        if (oERR_SPURIOUS !== 1'b0) $display("FAIL reset_spur got %b want 0", oERR_SPURIOUS);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read();
        set_req(1'b1, 2'd2, 32'h1000_0044, 32'h0);
        step();
        iCACHE_REQ = 0;
        checks++;
        if (oMEM_REQ !== 1'b1 || oMEM_BE !== 8'hFF)
            $display("FAIL t1_issue req=%b be=%h want 1/ff", oMEM_REQ, oMEM_BE);
        else passed++;
        checks++;
        if (oMEM_ADDR !== 32'h1000_0044 || oMEM_RW !== 1'b1 || oMEM_PDT !== 32'hCAFE_0000)
            $display("FAIL t1_fields addr=%h rw=%b pdt=%h", oMEM_ADDR, oMEM_RW, oMEM_PDT);
        else passed++;
        step();
        checks++;
        if (oMEM_REQ !== 1'b0) $display("FAIL t1_popped got %b want 0", oMEM_REQ);
        else passed++;
        iMEM_VALID = 1; iMEM_DATA = 64'h1122_3344_5566_7788;
        iMEM_MMU_FLAGS = 28'hABC_1234;
        step();
        iMEM_VALID = 0; iMEM_DATA = 0;
        checks++;
        if (oCACHE_VALID !== 1'b1 || oCACHE_DATA !== 64'h1122_3344_5566_7788)
            $display("FAIL t1_resp valid=%b data=%h want 1/1122334455667788",
                     oCACHE_VALID, oCACHE_DATA);
        else passed++;
        checks++;
        if (oCACHE_MMU_FLAGS !== 28'hABC_1234)
            $display("FAIL t1_flags got %h want abc1234", oCACHE_MMU_FLAGS);
        else passed++;
        step();
        checks++;
        if (oCACHE_VALID !== 1'b0 || oCACHE_DATA !== 64'h1122_3344_5566_7788)
            $display("FAIL t1_hold valid=%b data=%h", oCACHE_VALID, oCACHE_DATA);
        else passed++;
    endtask

    task automatic test_write_steer();
        iMEM_LOCK = 1;
        set_req(1'b0, 2'd0, 32'h0000_0003, 32'h0000_00AB);
        step();
        iCACHE_REQ = 0;
        checks++;
        if (oMEM_BE !== 8'h08 || oMEM_DATA !== 64'hABAB_ABAB_ABAB_ABAB)
            $display("FAIL t2_byte be=%h data=%h want 08/abab..", oMEM_BE, oMEM_DATA);
        else passed++;
        checks++;
        if (oMEM_RW !== 1'b0) $display("FAIL t2_rw got %b want 0", oMEM_RW);
        else passed++;
        iMEM_LOCK = 0;
        step();
        iMEM_VALID = 1; iMEM_DATA = 64'h0;
        step();
        iMEM_VALID = 0;
        checks++;
        if (oCACHE_VALID !== 1'b1) $display("FAIL t2_ack got %b want 1", oCACHE_VALID);
        else passed++;
        step();
        iMEM_LOCK = 1;
        set_req(1'b0, 2'd1, 32'h0000_0006, 32'h0000_BEEF);
        step();
        iCACHE_REQ = 0;
        checks++;
        if (oMEM_BE !== 8'hC0 || oMEM_DATA !== 64'hBEEF_BEEF_BEEF_BEEF)
            $display("FAIL t2_half be=%h data=%h want c0/beef..", oMEM_BE, oMEM_DATA);
        else passed++;
        iMEM_LOCK = 0;
        step();
        iMEM_VALID = 1;
        step();
        iMEM_VALID = 0;
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        int nv;
        iMEM_LOCK = 1;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 2'd2, 32'h200 + 32'(4 * i), 32'h0);
            #1;
            checks++;
            if (oCACHE_LOCK !== (i == 4))
                $display("FAIL t3_lock%0d got %b want %b", i, oCACHE_LOCK, (i == 4));
            else passed++;
            step();
        end
        iCACHE_REQ = 0;
        iMEM_LOCK = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h200 + 32'(4 * i);
            checks++;
            if (oMEM_REQ !== 1'b1 || oMEM_ADDR !== a)
                $display("FAIL t3_order%0d req=%b addr=%h want 1/%h", i, oMEM_REQ, oMEM_ADDR, a);
            else passed++;
            step();
        end
        checks++;
        if (oMEM_REQ !== 1'b0) $display("FAIL t3_drained got %b want 0", oMEM_REQ);
        else passed++;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            iMEM_VALID = 1;
            step();
            if (oCACHE_VALID === 1'b1) nv++;
        end
        iMEM_VALID = 0;
        step();
        checks++;
        if (nv != 4) $display("FAIL t3_valids got %0d want 4", nv);
        else passed++;
    endtask

    task automatic test_squash();
        int nv;
        int exp_nv;
        logic pf2;
        for (int k = 0; k < 8; k++) begin
            set_req(1'b1, 2'd2, 32'h2000_0000 + 32'(8 * k), 32'h0);
            step();
        end
        iCACHE_REQ = 0;
        step();
        set_req(1'b1, 2'd2, 32'h3000_0000, 32'h0);
        step();
        iCACHE_REQ = 0;
        checks++;
        if (oMEM_REQ !== 1'b0) $display("FAIL t4_outs_full got %b want 0", oMEM_REQ);
        else passed++;
        nv = 0;
        pf2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            iMEM_VALID = 1;
            iMEM_DATA = 64'(k);
            iMEM_PAGEFAULT = (k == 2);
            step();
            if (oCACHE_VALID === 1'b1) begin
                nv++;
                if (oCACHE_DATA === 64'd2) pf2 = oCACHE_PAGEFAULT;
            end
        end
`ifdef MIST1032ISA_DATA_RESP_PF_SQUASH_EN
        exp_nv = 3;
`else
        exp_nv = 8;
`endif
        checks++;
        if (nv != exp_nv) $display("FAIL t4_valids got %0d want %0d", nv, exp_nv);
        else passed++;
        checks++;
        if (pf2 !== 1'b1) $display("FAIL t4_pf got %b want 1", pf2);
        else passed++;
        iMEM_DATA = 64'h99;
        iMEM_PAGEFAULT = 0;
        step();
        iMEM_VALID = 0;
        checks++;
        if (oCACHE_VALID !== 1'b1 || oCACHE_DATA !== 64'h99 || oCACHE_PAGEFAULT !== 1'b0)
            $display("FAIL t4_next v=%b d=%h pf=%b want 1/99/0",
                     oCACHE_VALID, oCACHE_DATA, oCACHE_PAGEFAULT);
        else passed++;
        step();
    endtask

    task automatic test_spurious();
        checks++;
        if (oERR_SPURIOUS !== 1'b0) $display("FAIL t5_pre got %b want 0", oERR_SPURIOUS);
        else passed++;
        iMEM_VALID = 1; iMEM_DATA = 64'h5555;
        step();
        iMEM_VALID = 0;
        checks++;
        if (oCACHE_VALID !== 1'b0) $display("FAIL t5_novalid got %b want 0", oCACHE_VALID);
        else passed++;
        checks++;
        if (oERR_SPURIOUS !== 1'b1) $display("FAIL t5_set got %b want 1", oERR_SPURIOUS);
        else passed++;
        step(); step(); step();
        checks++;
        if (oERR_SPURIOUS !== 1'b1) $display("FAIL t5_sticky got %b want 1", oERR_SPURIOUS);
        else passed++;
    endtask

    task automatic test_remove();
        set_req(1'b1, 2'd2, 32'h4000_0000, 32'h0);
        step();
        set_req(1'b1, 2'd2, 32'h4000_0040, 32'h0);
        step();
        iCACHE_REQ = 0;
        step();
        iMEM_LOCK = 1;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b0, 2'd2, 32'h5000_0000 + 32'(4 * i), 32'h0);
            step();
        end
        iCACHE_REQ = 0;
        checks++;
        if (oMEM_REQ !== 1'b1) $display("FAIL t6_queued got %b want 1", oMEM_REQ);
        else passed++;
        iREMOVE = 1;
        #1;
        checks++;
        if (oCACHE_LOCK !== 1'b1 || oMEM_REQ !== 1'b0)
            $display("FAIL t6_during lock=%b req=%b want 1/0", oCACHE_LOCK, oMEM_REQ);
        else passed++;
        step();
        iREMOVE = 0;
        iMEM_LOCK = 0;
        #1;
        checks++;
        if (oMEM_REQ !== 1'b0 || oCACHE_LOCK !== 1'b0)
            $display("FAIL t6_empty req=%b lock=%b want 0/0", oMEM_REQ, oCACHE_LOCK);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            iMEM_VALID = 1;
            iMEM_DATA = 64'hA1 + 64'(i);
            step();
            checks++;
            if (oCACHE_VALID !== 1'b1 || oCACHE_DATA !== 64'hA1 + 64'(i))
                $display("FAIL t6_resp%0d v=%b d=%h want 1/%h",
                         i, oCACHE_VALID, oCACHE_DATA, 64'hA1 + 64'(i));
            else passed++;
        end
        iMEM_VALID = 0;
        step();
        checks++;
        if (oCACHE_VALID !== 1'b0) $display("FAIL t6_done got %b want 0", oCACHE_VALID);
        else passed++;
    endtask

    task automatic test_reset_midburst();
        set_req(1'b1, 2'd2, 32'h6000_0000, 32'h0);
        step();
        iCACHE_REQ = 0;
        step();
        rst_n = 0;
        #1;
        checks++;
        if (oERR_SPURIOUS !== 1'b0 || oMEM_REQ !== 1'b0)
            $display("FAIL rst_mid spur=%b req=%b want 0/0", oERR_SPURIOUS, oMEM_REQ);
        else passed++;
        @(negedge clk);
        rst_n = 1;
        step();
        iMEM_VALID = 1; iMEM_DATA = 64'h77;
        step();
        iMEM_VALID = 0;
        checks++;
        if (oCACHE_VALID !== 1'b0 || oERR_SPURIOUS !== 1'b1)
            $display("FAIL rst_late v=%b spur=%b want 0/1", oCACHE_VALID, oERR_SPURIOUS);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_steer();
        test_backpressure();
        test_squash();
        test_spurious();
        test_remove();
        test_reset_midburst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
